dmem_dump_responder: RTL and testbench

//  Data-memory responder for the pipelined LEGv8 core's DM interface.
//  - Serves the core's MEM-stage loads (combinational read) and stores (clocked write).
//  - On a rising edge of dump, a scan FSM streams every entry out over a valid/ready

---
 rtl/dmem_dump_responder.sv | 122 ++++++++++++
 tb/tb_dmem_dump_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_responder.sv
// Data memory for the LEGv8 core: combinational loads, clocked stores, and a
// valid/ready dump port that streams every entry (0 first) after a rising dump edge.
module dmem_dump_responder #(
  parameter int N     = 64,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memWrite,
  input  logic          memRead,
  input  logic [AW-1:0] address,
  input  logic [N-1:0]  writeData,
  output logic [N-1:0]  readData,
  input  logic          dump,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [N-1:0]  dump_data,
  output logic          dump_busy,
  output logic          dump_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  logic [N-1:0]  mem [DEPTH];
  state_t        state, state_d;
  logic [AW-1:0] idx, idx_d, idx_inc;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          dump_q, armed, trigger;

  // NOTE: the memory is cleared on reset, so it is a flop array with an async
  // reset rather than an inferred RAM macro (RAM macros cannot be bulk-cleared).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (memWrite) begin
      mem[address] <= writeData;
    end
  end

  // Same-cycle read-during-write sees the old word: the write lands at the edge.
  assign readData = memRead ? mem[address] : '0;

  // armed stays low after reset until dump is seen low, so a level held high
  // through reset cannot pose as a fresh rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      dump_q <= dump;
      armed  <= armed | ~dump;
    end
  end

  assign trigger = dump & ~dump_q & armed;
  assign idx_inc = idx + AW'(1);

  // NOTE: every sequential process uses non-blocking assignments so all state
  // updates at an edge see the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: each variable gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    data_d  = data_q;
    valid_d = valid_q;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_d = SCAN;
          idx_d   = '0;
          data_d  = mem[0];
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (valid_q && dump_ready) begin
          if (idx == AW'(DEPTH - 1)) begin
            state_d = DONE;
            idx_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
          end else begin
            // Snapshot is taken from the pre-edge memory, so a store at this
            // same edge does not leak into the beat.
            idx_d  = idx_inc;
            data_d = mem[idx_inc];
          end
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign dump_valid = valid_q;
  assign dump_addr  = (state == SCAN) ? idx : '0;
  assign dump_data  = data_q;
  assign dump_busy  = (state != IDLE);
  assign dump_done  = (state == DONE);

endmodule

// File: tb/tb_dmem_dump_responder.sv
// Self-checking bench for dmem_dump_responder: directed memory accesses plus
// dump scans checked by a scoreboard queue and an independent negedge monitor.
module tb_dmem_dump_responder;

  localparam int N     = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          memWrite, memRead;
  logic [AW-1:0] address;
  logic [N-1:0]  writeData;
  logic [N-1:0]  readData;
  logic          dump, dump_ready;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [N-1:0]  dump_data;
  logic          dump_busy, dump_done;

  int    pass_cnt  = 0;
  int    total_cnt = 0;
  int    done_cnt  = 0;
  int    stall_cnt = 0;
  beat_t exp_q[$];

  dmem_dump_responder #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .dump      (dump),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_busy (dump_busy),
    .dump_done (dump_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: samples on the falling edge, pops on a transfer, checks hold on a stall.
  always @(negedge clk) begin
    if (dump_done) begin
      done_cnt++;
      check("done_addr_zero", 64'(dump_addr), 64'd0);
      check("done_data_zero", dump_data, 64'd0);
    end
    if (dump_valid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_beat: got addr %0d data %h expected no beat", dump_addr, dump_data);
      end else if (dump_ready) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_addr", 64'(dump_addr), 64'(e.addr));
        check("beat_data", dump_data, e.data);
      end else begin
        stall_cnt++;
        check("stall_addr", 64'(dump_addr), 64'(exp_q[0].addr));
        check("stall_data", dump_data, exp_q[0].data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [N-1:0] d);
    memWrite  = 1'b1;
    address   = a;
    writeData = d;
    tick();
    memWrite  = 1'b0;
  endtask

  // Raises dump and counts edges until busy drops; also checks one-edge valid latency.
  task automatic run_scan(input string tag);
    int n;
    n = 0;
    done_cnt = 0;
    dump = 1'b1;
    while (1) begin
      tick();
      n++;
      if (n == 1) check({tag, "_valid_latency"}, 64'(dump_valid), 64'd1);
      if (n > 1 && !dump_busy) break;
      if (n > 400) begin
        total_cnt++;
        $display("FAIL %s_timeout: got %0d cycles expected busy to drop", tag, n);
        break;
      end
    end
    check({tag, "_dump_to_idle_cycles"}, 64'(n), 64'd66);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [N-1:0] img(input int i);
    return (i == 2) ? 64'h55 : 64'(i + 100);
  endfunction

  initial begin
    beat_t b;
    int    n;
    reset = 1'b0; memWrite = 1'b0; memRead = 1'b0; address = '0;
    writeData = '0; dump = 1'b0; dump_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Reset clears stored data even mid-simulation.
    store(6'd3, 64'h1234);
    memRead = 1'b1; address = 6'd3; #1;
    check("pre_reset_read", readData, 64'h1234);
    reset = 1'b0; #1;
    for (int i = 0; i < DEPTH; i++) begin
      address = AW'(i); #1;
      check("reset_read_zero", readData, 64'd0);
    end
    check("reset_valid", 64'(dump_valid), 64'd0);
    check("reset_busy", 64'(dump_busy), 64'd0);
    check("reset_done", 64'(dump_done), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Store then load; memRead gating; read-during-write returns old value.
    memRead = 1'b0;
    store(6'd5, 64'hDEADBEEF00000001);
    memRead = 1'b1; address = 6'd5; #1;
    check("load_after_store", readData, 64'hDEADBEEF00000001);
    memRead = 1'b0; #1;
    check("read_gated_zero", readData, 64'd0);
    memRead = 1'b1; memWrite = 1'b1; writeData = 64'hAAAA; #1;
    check("rdw_old_value", readData, 64'hDEADBEEF00000001);
    tick();
    memWrite = 1'b0; #1;
    check("rdw_new_value", readData, 64'hAAAA);
    memRead = 1'b0;

    // Full scan with ready tied high.
    for (int i = 0; i < DEPTH; i++) store(AW'(i), 64'(i + 100));
    for (int i = 0; i < DEPTH; i++) begin
      b.addr = AW'(i); b.data = 64'(i + 100);
      exp_q.push_back(b);
    end
    run_scan("scan1");

    // Dump still high: no retrigger.
    repeat (5) tick();
    check("held_dump_no_retrigger", 64'(dump_busy), 64'd0);
    dump = 1'b0;
    tick();

    // Backpressure at entry 2 with a store to entry 2 during the stall.
    for (int i = 0; i < DEPTH; i++) begin
      b.addr = AW'(i); b.data = 64'(i + 100);
      exp_q.push_back(b);
    end
    stall_cnt = 0;
    dump = 1'b1;
    n = 0;
    while (!(dump_valid && dump_addr == 6'd2) && n < 20) begin
      tick();
      n++;
    end
    check("reached_addr2", 64'(dump_addr), 64'd2);
    dump_ready = 1'b0;
    store(6'd2, 64'h55);
    repeat (2) tick();
    dump_ready = 1'b1;
    n = 0;
    while (dump_busy && n < 200) begin
      tick();
      n++;
    end
    check("stall_cycles", 64'(stall_cnt), 64'd3);
    check("scan2_queue_drained", 64'(exp_q.size()), 64'd0);
    memRead = 1'b1; address = 6'd2; #1;
    check("read_after_stall_store", readData, 64'h55);
    memRead = 1'b0;
    dump = 1'b0;
    tick();

    // Reset during a scan at entry 10 with dump held high.
    for (int i = 0; i < 10; i++) begin
      b.addr = AW'(i); b.data = img(i);
      exp_q.push_back(b);
    end
    dump = 1'b1;
    n = 0;
    while (!(dump_valid && dump_addr == 6'd10) && n < 40) begin
      tick();
      n++;
    end
    check("reached_addr10", 64'(dump_addr), 64'd10);
    reset = 1'b0; #1;
    check("abort_valid", 64'(dump_valid), 64'd0);
    check("abort_busy", 64'(dump_busy), 64'd0);
    check("abort_done", 64'(dump_done), 64'd0);
    check("abort_data", dump_data, 64'd0);
    check("abort_queue_drained", 64'(exp_q.size()), 64'd0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check("no_rescan_after_reset", 64'(dump_busy), 64'd0);
    check("no_valid_after_reset", 64'(dump_valid), 64'd0);

    // Fresh edge rescans the now-cleared memory.
    dump = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      b.addr = AW'(i); b.data = '0;
      exp_q.push_back(b);
    end
    run_scan("scan3");
    dump = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
